// File: rtl/sram_arb_pkg.sv
// Shared geometry, FSM state and grant encodings for the SRAM read/write arbiter.
// Geometry: 128 entries of 24 bits, with 4 write-mask lanes of 6 bits each.
package sram_arb_pkg;

   localparam int unsigned DEPTH  = 128;
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned DATA_W = 24;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned GRAN   = DATA_W / MASK_W;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef enum logic {
      GNT_W = 1'b0,
      GNT_R = 1'b1
   } grant_e;

   function automatic grant_e other_side(input grant_e g);
      return (g == GNT_W) ? GNT_R : GNT_W;
   endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry flop FIFO that holds read responses captured from the macro.
// Reset clears the pointers and the count only; the data entries keep their contents.
module sram_resp_fifo
   import sram_arb_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        cnt,
   output logic [DATA_W-1:0] head
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign cnt  = cnt_q;
   assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_rw_arbiter.sv
// Round-robin sequencer for one write and one read requester sharing a single-port masked SRAM.
// Define SRAM_ARB_INIT_SWEEP_EN to zero-fill the macro after every reset.
module sram_rw_arbiter
   import sram_arb_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [MASK_W-1:0] w_mask,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              init_done,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [MASK_W-1:0] sram_wmask,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   state_e     state_q, state_d;
   grant_e     rr_ptr_q;  // side that wins the next contended cycle
   logic       ren_q;
   logic [1:0] q_cnt;
   logic [2:0] occ;
   logic       run;
   logic       pop;
   logic       rd_ok;
   logic       r_req;
   logic       grant_w;
   logic       grant_r;
   logic       sweep_last;

`ifdef SRAM_ARB_INIT_SWEEP_EN
   logic [ADDR_W-1:0] sweep_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sweep_q <= '0;
      end else if (state_q == INIT && !sweep_last) begin
         sweep_q <= sweep_q + ADDR_W'(1);
      end
   end

   assign sweep_last = (sweep_q == ADDR_W'(DEPTH - 1));
`else
   assign sweep_last = 1'b1;
`endif

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:    if (sweep_last) state_d = RUN;
         RUN:     state_d = RUN;
      endcase
   end

   assign run        = (state_q == RUN);
   assign init_done  = run;
   assign resp_valid = (q_cnt != 2'd0);
   assign pop        = resp_valid && resp_ready;

   // Slots already claimed by queued or in-flight reads, net of this cycle's pop.
   assign occ   = {1'b0, q_cnt} + {2'b00, ren_q} - {2'b00, pop};
   assign rd_ok = (occ < 3'd2);
   assign r_req = r_valid && rd_ok;

   assign w_ready = run && (!r_req || rr_ptr_q == GNT_W);
   assign r_ready = run && rd_ok && (!w_valid || rr_ptr_q == GNT_R);
   assign grant_w = w_valid && w_ready;
   assign grant_r = r_valid && r_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q <= GNT_W;
         ren_q    <= 1'b0;
      end else begin
         if (grant_w) begin
            rr_ptr_q <= other_side(GNT_W);
         end else if (grant_r) begin
            rr_ptr_q <= other_side(GNT_R);
         end
         ren_q <= grant_r;
      end
   end

   // FSM outputs: macro port mux
   always_comb begin
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wmask = '0;
      sram_wdata = '0;
      unique case (state_q)
         INIT: begin
`ifdef SRAM_ARB_INIT_SWEEP_EN
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_q;
            sram_wmask = '1;
`endif
         end
         RUN: begin
            if (grant_w) begin
               sram_en    = 1'b1;
               sram_wmode = 1'b1;
               sram_addr  = w_addr;
               sram_wmask = w_mask;
               sram_wdata = w_data;
            end else if (grant_r) begin
               sram_en   = 1'b1;
               sram_addr = r_addr;
            end
         end
      endcase
   end

   sram_resp_fifo u_resp_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (ren_q),
      .push_data (sram_rdata),
      .pop       (pop),
      .cnt       (q_cnt),
      .head      (resp_data)
   );

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: directed and random traffic against a transaction-level model
// (memory array plus expected-response queue). Honours SRAM_ARB_INIT_SWEEP_EN.
module tb_sram_rw_arbiter;
   import sram_arb_pkg::*;

`ifdef SRAM_ARB_INIT_SWEEP_EN
   localparam int INIT_CYC = DEPTH;
   localparam bit SWEEP    = 1'b1;
`else
   localparam int INIT_CYC = 1;
   localparam bit SWEEP    = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              w_valid, w_ready, r_valid, r_ready;
   logic [ADDR_W-1:0] w_addr, r_addr, sram_addr;
   logic [MASK_W-1:0] w_mask, sram_wmask;
   logic [DATA_W-1:0] w_data, resp_data, sram_wdata, sram_rdata;
   logic              resp_valid, resp_ready, init_done, sram_en, sram_wmode;

   always #5 clock = ~clock;

   sram_rw_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_addr     (w_addr),
      .w_mask     (w_mask),
      .w_data     (w_data),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .r_addr     (r_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .init_done  (init_done),
      .sram_en    (sram_en),
      .sram_wmode (sram_wmode),
      .sram_addr  (sram_addr),
      .sram_wmask (sram_wmask),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   // Macro model: garbage preload when the sweep is expected to clear it.
   logic [DATA_W-1:0] mem [DEPTH];
   bit                mem_loaded = 1'b0;

   always @(posedge clock) begin
      if (!mem_loaded) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= SWEEP ? DATA_W'($urandom) : '0;
         mem_loaded <= 1'b1;
      end else if (sram_en) begin
         if (sram_wmode) begin
            for (int i = 0; i < MASK_W; i++)
               if (sram_wmask[i]) mem[sram_addr][i*GRAN +: GRAN] <= sram_wdata[i*GRAN +: GRAN];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   typedef struct {
      logic [DATA_W-1:0] data;
      int                t;
   } resp_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [MASK_W-1:0] mask;
      logic [DATA_W-1:0] data;
   } wreq_t;

   logic [DATA_W-1:0] ref_mem [DEPTH];
   resp_t             exp_q[$];
   wreq_t             wq[$];
   logic [ADDR_W-1:0] rq[$];
   int                now;
   bit                last_was_w;
   bit                w_fired, r_fired;
   int                tests = 0;
   int                fails = 0;
   int                r_acc = 0;
   int                r_base;
   logic [DATA_W-1:0] last_pop;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance the transaction model.
   task automatic cycle();
      bit    running, head_rdy, popping, room, w_rdy, r_rdy;
      resp_t item;
      @(negedge clock);
      running  = now >= INIT_CYC;
      head_rdy = exp_q.size() > 0 && now >= exp_q[0].t + 2;
      popping  = head_rdy && resp_ready;
      room     = (exp_q.size() - int'(popping)) < 2;
      w_rdy    = running && (!(r_valid && room) || !last_was_w);
      r_rdy    = running && room && (!w_valid || last_was_w);
      w_fired  = w_valid && w_rdy;
      r_fired  = r_valid && r_rdy;
      chk("init_done", init_done, running);
      chk("w_ready", w_ready, w_rdy);
      chk("r_ready", r_ready, r_rdy);
      chk("resp_valid", resp_valid, head_rdy);
      if (head_rdy) chk("resp_data", resp_data, exp_q[0].data);
      if (!running) begin
`ifdef SRAM_ARB_INIT_SWEEP_EN
         chk("sweep_port", {sram_en, sram_wmode, sram_wmask, sram_wdata}, {2'b11, 4'hF, 24'h0});
         chk("sweep_addr", sram_addr, now);
`else
         chk("init_idle", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}, 0);
`endif
      end else if (w_fired) begin
         chk("wr_port", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
             {2'b11, w_addr, w_mask, w_data});
      end else if (r_fired) begin
         chk("rd_port", {sram_en, sram_wmode, sram_addr}, {2'b10, r_addr});
      end else begin
         chk("idle_port", {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}, 0);
      end
      if (popping) begin
         last_pop = exp_q[0].data;
         void'(exp_q.pop_front());
      end
      if (w_fired) begin
         for (int i = 0; i < MASK_W; i++)
            if (w_mask[i]) ref_mem[w_addr][i*GRAN +: GRAN] = w_data[i*GRAN +: GRAN];
         last_was_w = 1'b1;
      end
      if (r_fired) begin
         item.data = ref_mem[r_addr];
         item.t    = now;
         exp_q.push_back(item);
         last_was_w = 1'b0;
         r_acc++;
      end
      now++;
      @(posedge clock);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         w_valid = wq.size() > 0;
         w_addr  = w_valid ? wq[0].addr : '0;
         w_mask  = w_valid ? wq[0].mask : '0;
         w_data  = w_valid ? wq[0].data : '0;
         r_valid = rq.size() > 0;
         r_addr  = r_valid ? rq[0] : '0;
         cycle();
         if (w_fired) void'(wq.pop_front());
         if (r_fired) void'(rq.pop_front());
      end
      w_valid = 1'b0;
      r_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      resp_ready = 1'b1;
      for (int i = 0; i < budget && (wq.size() + rq.size() + exp_q.size()) > 0; i++)
         run_cycles(1);
      chk(tag, wq.size() + rq.size() + exp_q.size(), 0);
   endtask

   task automatic do_reset();
      w_valid = 1'b0;
      r_valid = 1'b0;
      reset   = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      now   = 0;
      exp_q.delete();
      wq.delete();
      rq.delete();
      last_was_w = 1'b0;
`ifdef SRAM_ARB_INIT_SWEEP_EN
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
   endtask

   function automatic wreq_t mk_w(input int a, input int m, input int d);
      wreq_t w;
      w.addr = ADDR_W'(a);
      w.mask = MASK_W'(m);
      w.data = DATA_W'(d);
      return w;
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      w_addr = '0; w_mask = '0; w_data = '0; r_addr = '0; resp_ready = 1'b1;
      do_reset();

      // Init window, then read back the whole array.
      run_cycles(INIT_CYC + 2);
      for (int a = 0; a < DEPTH; a++) rq.push_back(ADDR_W'(a));
      drain("t1_drain", 600);

      // Masked write: lanes 0 and 2 of 24'hABCDEF land on a zeroed word.
      wq.push_back(mk_w(5, 4'b0101, 24'hABCDEF));
      drain("t2_wdrain", 20);
      rq.push_back(ADDR_W'(5));
      drain("t2_rdrain", 20);
      chk("t2_masked", last_pop, 24'h03C02F);

      // Contention: both sides requesting every cycle must alternate W,R.
      for (int i = 0; i < 4; i++) begin
         wq.push_back(mk_w(16 + i, 4'hF, int'($urandom)));
         rq.push_back(ADDR_W'(16 + i));
      end
      run_cycles(8);
      chk("t3_alternate", wq.size() + rq.size(), 0);
      drain("t3_drain", 20);

      // Backpressure: only two reads fit while the consumer stalls.
      resp_ready = 1'b0;
      r_base = r_acc;
      for (int i = 0; i < 5; i++) rq.push_back(ADDR_W'(16 + i));
      run_cycles(6);
      chk("t4_accepted", r_acc - r_base, 2);
      chk("t4_r_ready", r_ready, 1'b0);
      drain("t4_drain", 40);
      chk("t4_total", r_acc - r_base, 5);

      // Read after write sees new data; read before write sees old data.
      wq.push_back(mk_w(9, 4'hF, 24'h111111));
      run_cycles(1);
      rq.push_back(ADDR_W'(9));
      drain("t5a_drain", 20);
      chk("t5_raw", last_pop, 24'h111111);
      rq.push_back(ADDR_W'(9));
      run_cycles(1);
      wq.push_back(mk_w(9, 4'hF, 24'h222222));
      drain("t5b_drain", 20);
      chk("t5_war", last_pop, 24'h111111);
      rq.push_back(ADDR_W'(9));
      drain("t5c_drain", 20);
      chk("t5_new", last_pop, 24'h222222);

      // Random traffic on a small address window.
      for (int c = 0; c < 500; c++) begin
         if (wq.size() < 2 && $urandom_range(0, 1) == 1)
            wq.push_back(mk_w(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                              int'($urandom)));
         if (rq.size() < 2 && $urandom_range(0, 1) == 1)
            rq.push_back(ADDR_W'($urandom_range(0, 7)));
         resp_ready = ($urandom_range(0, 2) != 0);
         run_cycles(1);
      end
      drain("rand_drain", 50);

      // Reset with one response queued and one read in flight.
      resp_ready = 1'b0;
      r_base = r_acc;
      for (int i = 0; i < 3; i++) rq.push_back(ADDR_W'(i));
      run_cycles(2);
      chk("t6_inflight", r_acc - r_base, 2);
      do_reset();
      resp_ready = 1'b1;
      run_cycles(INIT_CYC + 3);
      rq.push_back(ADDR_W'(9));
      drain("t6_drain", 20);
      chk("t6_post_reset", last_pop, SWEEP ? 24'h0 : 24'h222222);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
